// File: rtl/resp_signature_monitor.sv
// Response-side MISR monitor: folds the sampled output bus into a signature over a
// programmed window and compares the result with a reference word latched at start.
module resp_signature_monitor #(
    parameter int               OUT_W       = 330,
    parameter int               SIG_W       = 32,
    parameter logic [SIG_W-1:0] POLY        = 32'h04C11DB7,
    parameter logic [SIG_W-1:0] SIG_SEED    = 32'h00000000,
    parameter int               SKIP_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [31:0]      num_cycles,
    input  logic [SIG_W-1:0] expected_sig,
    input  logic [OUT_W-1:0] out_flat,
    output logic             busy,
    output logic             done,
    output logic             match,
    output logic [SIG_W-1:0] signature,
    output logic [31:0]      sample_count
);

    localparam int NCH = (OUT_W + SIG_W - 1) / SIG_W;

    // XOR of all SIG_W-bit chunks; the top partial chunk is zero-extended.
    function automatic logic [SIG_W-1:0] fold_bus(input logic [OUT_W-1:0] bus);
        logic [NCH*SIG_W-1:0] padded;
        logic [SIG_W-1:0]     acc;
        padded            = '0;
        padded[OUT_W-1:0] = bus;
        acc               = '0;
        for (int k = 0; k < NCH; k++) begin
            acc = acc ^ padded[k*SIG_W +: SIG_W];
        end
        return acc;
    endfunction

    function automatic logic [SIG_W-1:0] misr_step(input logic [SIG_W-1:0] sig,
                                                   input logic [SIG_W-1:0] fold);
        return {sig[SIG_W-2:0], 1'b0} ^ (sig[SIG_W-1] ? POLY : '0) ^ fold;
    endfunction

    typedef enum logic [1:0] {IDLE, SKIP, RUN, DONE} state_t;

    state_t           state, state_nxt;
    logic [31:0]      skip_cnt;
    logic [31:0]      num_lat;
    logic [SIG_W-1:0] exp_lat;
    logic [SIG_W-1:0] sig_r;
    logic [31:0]      cnt_r;
    logic             match_r;

    logic accept, kill, skip_last, run_last, sig_eq;

    assign accept    = (state == IDLE) && start && !abort;
    assign kill      = ((state == SKIP) || (state == RUN)) && abort;
    assign skip_last = (skip_cnt == 32'(SKIP_CYCLES - 1));
    assign run_last  = ((cnt_r + 32'd1) == num_lat);
    assign sig_eq    = (sig_r == exp_lat);

    assign busy         = (state == SKIP) || (state == RUN);
    assign done         = (state == DONE);
    // The comparison is live during the DONE cycle and then held in match_r.
    assign match        = done ? sig_eq : match_r;
    assign signature    = sig_r;
    assign sample_count = cnt_r;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (SKIP_CYCLES > 0)         state_nxt = SKIP;
                    else if (num_cycles == 32'd0) state_nxt = DONE;
                    else                          state_nxt = RUN;
                end
            end
            SKIP: begin
                if (abort)          state_nxt = IDLE;
                else if (skip_last) state_nxt = (num_lat == 32'd0) ? DONE : RUN;
            end
            RUN: begin
                if (abort)         state_nxt = IDLE;
                else if (run_last) state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            skip_cnt <= '0;
            num_lat  <= '0;
            exp_lat  <= '0;
            sig_r    <= SIG_SEED;
            cnt_r    <= '0;
            match_r  <= 1'b0;
        end else if (accept) begin
            num_lat  <= num_cycles;
            exp_lat  <= expected_sig;
            sig_r    <= SIG_SEED;
            cnt_r    <= '0;
            match_r  <= 1'b0;
            skip_cnt <= '0;
        end else if (kill) begin
            sig_r    <= SIG_SEED;
            cnt_r    <= '0;
            match_r  <= 1'b0;
            skip_cnt <= '0;
        end else begin
            case (state)
                SKIP: skip_cnt <= skip_last ? '0 : skip_cnt + 32'd1;
                RUN: begin
                    sig_r <= misr_step(sig_r, fold_bus(out_flat));
                    cnt_r <= cnt_r + 32'd1;
                end
                DONE:    match_r <= sig_eq;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_resp_signature_monitor.sv
// Self-checking bench for resp_signature_monitor: directed corner windows plus
// randomized responses checked against a bit-level reference model.
module tb_resp_signature_monitor;

    localparam int          OUT_W = 330;
    localparam logic [31:0] POLY  = 32'h04C11DB7;

    logic             clk = 1'b0;
    logic             rst, start, abort;
    logic [31:0]      num_cycles, expected_sig;
    logic [OUT_W-1:0] out_flat;
    logic             busy, done, match;
    logic [31:0]      signature, sample_count;

    int n_cmp = 0;
    int n_bad = 0;

    logic [OUT_W-1:0] vals [0:63];

    resp_signature_monitor #(
        .OUT_W(OUT_W), .SIG_W(32), .POLY(POLY), .SIG_SEED(32'h0), .SKIP_CYCLES(2)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .num_cycles(num_cycles), .expected_sig(expected_sig), .out_flat(out_flat),
        .busy(busy), .done(done), .match(match),
        .signature(signature), .sample_count(sample_count)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, got, want);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [OUT_W-1:0] rand_bus();
        logic [351:0] tmp;
        for (int w = 0; w < 11; w++) tmp[w*32 +: 32] = $urandom;
        return tmp[OUT_W-1:0];
    endfunction

    // Reference: each bus bit i lands on signature bit (i mod 32), then a Galois LFSR shift.
    function automatic logic [31:0] ref_sig(input int n);
        logic [31:0] s, f;
        s = 32'h0;
        for (int t = 0; t < n; t++) begin
            f = 32'h0;
            for (int i = 0; i < OUT_W; i++) f[i % 32] = f[i % 32] ^ vals[t][i];
            s = {s[30:0], 1'b0} ^ (s[31] ? POLY : 32'h0) ^ f;
        end
        return s;
    endfunction

    task automatic prepare(input int pattern);
        logic [OUT_W-1:0] v;
        for (int t = 0; t < 64; t++) begin
            v = '0;
            case (pattern)
                1: v[0] = 1'b1;
                2: v[32] = 1'b1;
                3: begin v[0] = 1'b1; v[320] = 1'b1; end
                4: v = rand_bus();
                5: if (t == 0) v[31] = 1'b1;
                default: v = '0;
            endcase
            vals[t] = v;
        end
    endtask

    task automatic do_window(input int n, input logic [31:0] expv, input bit stray);
        logic [31:0] want;
        logic        wm;
        want = ref_sig(n);
        wm   = (want == expv);
        num_cycles = n; expected_sig = expv; start = 1'b1;
        tick;
        start = 1'b0;
        check_eq("busy_after_start", {31'b0, busy}, 32'd1);
        for (int k = 1; k <= n + 3; k++) begin
            if (k >= 3 && (k - 3) < n) out_flat = vals[k-3];
            else                       out_flat = rand_bus();
            if (stray && k == 3) begin
                start = 1'b1; num_cycles = n + 7; expected_sig = ~expv;
            end
            tick;
            start = 1'b0; num_cycles = n; expected_sig = expv;
            check_eq("done_timing", {31'b0, done}, {31'b0, (k == n + 2)});
            check_eq("busy_timing", {31'b0, busy}, {31'b0, (k < n + 2)});
            if (k >= n + 2) begin
                check_eq("signature", signature, want);
                check_eq("sample_count", sample_count, n);
                check_eq("match", {31'b0, match}, {31'b0, wm});
            end
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0;
        num_cycles = '0; expected_sig = '0; out_flat = '0;
        tick; tick;
        check_eq("rst_busy", {31'b0, busy}, 32'd0);
        check_eq("rst_done", {31'b0, done}, 32'd0);
        check_eq("rst_match", {31'b0, match}, 32'd0);
        check_eq("rst_sig", signature, 32'h0);
        check_eq("rst_cnt", sample_count, 32'd0);
        rst = 1'b0;
        tick;

        prepare(0); do_window(5, 32'h0, 1'b0);
        prepare(1); do_window(1, 32'h1, 1'b0);
        check_eq("bit0_n1_const", signature, 32'h00000001);
        do_window(2, 32'h3, 1'b0);
        check_eq("bit0_n2_const", signature, 32'h00000003);
        prepare(2); do_window(1, 32'h1, 1'b0);
        do_window(2, 32'h3, 1'b0);
        prepare(3); do_window(1, 32'h0, 1'b0);
        prepare(5); do_window(2, 32'h04C11DB7, 1'b0);
        check_eq("feedback_const", signature, 32'h04C11DB7);
        do_window(2, 32'h04C11DB8, 1'b0);
        prepare(0); do_window(0, 32'h0, 1'b0);
        do_window(0, 32'h1234, 1'b0);

        for (int r = 0; r < 6; r++) begin
            int          n;
            logic [31:0] e;
            prepare(4);
            n = $urandom_range(1, 40);
            e = ref_sig(n) ^ (($urandom_range(0, 1) == 1) ? 32'h0 : 32'h1);
            do_window(n, e, (r % 2) == 1);
        end
        prepare(4); do_window(6, ref_sig(6), 1'b1);

        // Abort on the third RUN cycle.
        prepare(4);
        num_cycles = 10; expected_sig = 32'h0; start = 1'b1;
        tick;
        start = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            out_flat = (k >= 3) ? vals[k-3] : rand_bus();
            tick;
        end
        check_eq("pre_abort_cnt", sample_count, 32'd2);
        check_eq("pre_abort_sig", signature, ref_sig(2));
        abort = 1'b1; out_flat = vals[2];
        tick;
        abort = 1'b0;
        check_eq("abort_busy", {31'b0, busy}, 32'd0);
        check_eq("abort_sig", signature, 32'h0);
        check_eq("abort_cnt", sample_count, 32'd0);
        for (int k = 0; k < 12; k++) begin
            out_flat = rand_bus();
            tick;
            check_eq("abort_no_done", {31'b0, done}, 32'd0);
        end

        // Async reset mid-RUN, between edges.
        prepare(4); do_window(3, ref_sig(3), 1'b0);
        check_eq("pre_rst_match", {31'b0, match}, 32'd1);
        num_cycles = 10; start = 1'b1;
        tick;
        start = 1'b0;
        for (int k = 1; k <= 5; k++) begin out_flat = rand_bus(); tick; end
        #2 rst = 1'b1;
        #1;
        check_eq("arst_busy", {31'b0, busy}, 32'd0);
        check_eq("arst_sig", signature, 32'h0);
        check_eq("arst_cnt", sample_count, 32'd0);
        check_eq("arst_match", {31'b0, match}, 32'd0);
        check_eq("arst_done", {31'b0, done}, 32'd0);
        tick;
        rst = 1'b0;
        tick;
        prepare(4); do_window(8, ref_sig(8), 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "timeout");
    end

endmodule
